// File: rtl/stp_frame_collector.sv
// Serial-to-parallel frame collector with a shadow bank and an output bank.
// Samples fill the shadow bank; complete frames move to par_out when it is free.
module stp_frame_collector #(
  parameter  int WIDTH     = 16,
  parameter  int NUM_WORDS = 32,
  localparam int CW        = $clog2(NUM_WORDS + 1)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       in_strobe,
  input  logic [WIDTH-1:0]           serial_in,
  input  logic                       clear,
  input  logic                       frame_ack,
  output logic [NUM_WORDS*WIDTH-1:0] par_out,
  output logic                       frame_valid,
  output logic                       overrun,
  output logic [CW-1:0]              fill_count
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_WORDS);

  logic [0:0]                 state;
  logic [NUM_WORDS*WIDTH-1:0] shadow;
  logic [NUM_WORDS*WIDTH-1:0] direct_frame;
  logic                       last_word;
  logic                       bank_free;
  logic                       ack_seen;

  assign ack_seen  = frame_ack && frame_valid;
  assign bank_free = !frame_valid || frame_ack;
  assign last_word = in_strobe && (fill_count == LAST);

  // Final sample bypasses the shadow so the frame lands with zero latency.
  assign direct_frame = {serial_in,
                         shadow[(NUM_WORDS-1)*WIDTH-1:0]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= FILL;
      shadow      <= '0;
      par_out     <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      fill_count  <= '0;
    end else if (clear) begin
      state       <= FILL;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      fill_count  <= '0;
    end else begin
      overrun <= 1'b0;
      unique case (state)
        FILL: begin
          if (in_strobe) begin
            shadow[int'(fill_count)*WIDTH +: WIDTH] <= serial_in;
          end
          if (last_word) begin
            if (bank_free) begin
              par_out     <= direct_frame;
              frame_valid <= 1'b1;
              fill_count  <= '0;
            end else begin
              state      <= HOLD;
              fill_count <= FULL;
            end
          end else begin
            if (in_strobe) begin
              fill_count <= fill_count + 1'b1;
            end
            if (ack_seen) begin
              frame_valid <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (frame_ack) begin
            par_out <= shadow;
            state   <= FILL;
            if (in_strobe) begin
              shadow[WIDTH-1:0] <= serial_in;
              fill_count        <= CW'(1);
            end else begin
              fill_count <= '0;
            end
          end else if (in_strobe) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stp_frame_collector.sv
// Directed bench for stp_frame_collector.
// Expected frames are queued at stimulus time and popped on transfer.
module tb_stp_frame_collector;

  localparam int WIDTH     = 16;
  localparam int NUM_WORDS = 32;
  localparam int CW        = $clog2(NUM_WORDS + 1);
  localparam int PW        = NUM_WORDS * WIDTH;

  logic              tb_clk;
  logic              n_rst;
  logic              in_strobe;
  logic [WIDTH-1:0]  serial_in;
  logic              clear;
  logic              frame_ack;
  logic [PW-1:0]     par_out;
  logic              frame_valid;
  logic              overrun;
  logic [CW-1:0]     fill_count;

  logic [PW-1:0]     exp_q[$];
  logic [PW-1:0]     cur_frame;
  int                n_checks;
  int                n_pass;

  stp_frame_collector #(
    .WIDTH     (WIDTH),
    .NUM_WORDS (NUM_WORDS)
  ) dut (
    .clk         (tb_clk),
    .n_rst       (n_rst),
    .in_strobe   (in_strobe),
    .serial_in   (serial_in),
    .clear       (clear),
    .frame_ack   (frame_ack),
    .par_out     (par_out),
    .frame_valid (frame_valid),
    .overrun     (overrun),
    .fill_count  (fill_count)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  function automatic logic [PW-1:0] make_frame(input int base);
    logic [PW-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      f[k*WIDTH +: WIDTH] = WIDTH'(base + k);
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic chk_bus(input string tag, input logic [PW-1:0] obs,
                         input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic chk_frame(input string tag);
    logic [PW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: scoreboard empty, got %h", tag, par_out);
    end else begin
      e = exp_q.pop_front();
      chk_bus(tag, par_out, e);
      cur_frame = e;
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    in_strobe = 1'b1;
    serial_in = d;
    step();
    in_strobe = 1'b0;
  endtask

  task automatic send_frame(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      send(WIDTH'(base + k));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    cur_frame = '0;
    n_rst     = 1'b0;
    clear     = 1'b0;
    frame_ack = 1'b0;
    in_strobe = 1'b0;
    serial_in = '0;

    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      in_strobe = 1'($urandom);
      serial_in = WIDTH'($urandom);
      clear     = 1'($urandom);
      frame_ack = 1'($urandom);
      step();
    end
    chk_bus("rst_par", par_out, '0);
    chk("rst_valid", 32'(frame_valid), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_fill", 32'(fill_count), 0);
    in_strobe = 1'b0;
    serial_in = '0;
    clear     = 1'b0;
    frame_ack = 1'b0;
    n_rst     = 1'b1;
    step();

    // 2: back-to-back frame
    send_frame(0, NUM_WORDS - 1);
    chk("b2b_valid_pre", 32'(frame_valid), 0);
    chk("b2b_fill_pre", 32'(fill_count), NUM_WORDS - 1);
    exp_q.push_back(make_frame(0));
    send(WIDTH'(NUM_WORDS - 1));
    chk("b2b_valid", 32'(frame_valid), 1);
    chk("b2b_fill", 32'(fill_count), 0);
    chk_frame("b2b_par");
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk("ack_valid", 32'(frame_valid), 0);
    chk_bus("ack_par_held", par_out, cur_frame);

    // 3: sparse strobes
    for (int k = 0; k < NUM_WORDS - 1; k++) begin
      send(WIDTH'(k));
      step();
      step();
      chk("sparse_valid", 32'(frame_valid), 0);
    end
    chk("sparse_fill_pre", 32'(fill_count), NUM_WORDS - 1);
    exp_q.push_back(make_frame(0));
    send(WIDTH'(NUM_WORDS - 1));
    chk("sparse_valid_end", 32'(frame_valid), 1);
    chk("sparse_fill", 32'(fill_count), 0);
    chk_frame("sparse_par");

    // 4: second frame fills shadow while output occupied
    send_frame(32'h20, NUM_WORDS);
    exp_q.push_back(make_frame(32'h20));
    chk("hold_fill", 32'(fill_count), NUM_WORDS);
    chk("hold_valid", 32'(frame_valid), 1);
    chk("hold_ovr0", 32'(overrun), 0);
    for (int i = 0; i < 3; i++) begin
      send(16'hdead);
      chk("drop_ovr", 32'(overrun), 1);
      chk("drop_fill", 32'(fill_count), NUM_WORDS);
    end
    step();
    chk("drop_ovr_end", 32'(overrun), 0);
    chk_bus("drop_par_held", par_out, cur_frame);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    chk_frame("hold_ack_par");
    chk("hold_ack_valid", 32'(frame_valid), 1);
    chk("hold_ack_fill", 32'(fill_count), 0);

    // 5: ack coincident with last word
    for (int k = 0; k < NUM_WORDS - 1; k++) begin
      send(WIDTH'(32'h100 + k));
      chk("coin_ovr", 32'(overrun), 0);
    end
    exp_q.push_back(make_frame(32'h100));
    frame_ack = 1'b1;
    send(WIDTH'(32'h100 + NUM_WORDS - 1));
    frame_ack = 1'b0;
    chk("coin_valid", 32'(frame_valid), 1);
    chk("coin_fill", 32'(fill_count), 0);
    chk("coin_ovr_end", 32'(overrun), 0);
    chk_frame("coin_par");

    // 5b: ack plus strobe while holding
    send_frame(32'h200, NUM_WORDS);
    exp_q.push_back(make_frame(32'h200));
    chk("hs_fill_pre", 32'(fill_count), NUM_WORDS);
    frame_ack = 1'b1;
    send(16'h0777);
    frame_ack = 1'b0;
    chk_frame("hs_par");
    chk("hs_fill", 32'(fill_count), 1);
    chk("hs_ovr", 32'(overrun), 0);
    chk("hs_valid", 32'(frame_valid), 1);

    // 6: clear with a strobe in the same cycle
    clear = 1'b1;
    send(16'hbeef);
    clear = 1'b0;
    chk("clr_fill", 32'(fill_count), 0);
    chk("clr_valid", 32'(frame_valid), 0);
    chk("clr_ovr", 32'(overrun), 0);
    chk_bus("clr_par_kept", par_out, cur_frame);
    send_frame(32'h55, 10);
    chk("part_fill", 32'(fill_count), 10);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr2_fill", 32'(fill_count), 0);
    chk("clr2_valid", 32'(frame_valid), 0);
    exp_q.push_back(make_frame(32'ha000));
    send_frame(32'ha000, NUM_WORDS);
    chk("clr_frame_valid", 32'(frame_valid), 1);
    chk_frame("clr_frame_par");

    // 6b: asynchronous reset mid-frame
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    send_frame(32'h66, 10);
    #2;
    n_rst = 1'b0;
    #1;
    chk_bus("arst_par", par_out, '0);
    chk("arst_fill", 32'(fill_count), 0);
    chk("arst_valid", 32'(frame_valid), 0);
    step();
    n_rst = 1'b1;
    step();
    exp_q.push_back(make_frame(32'ha000));
    send_frame(32'ha000, NUM_WORDS);
    chk("arst_frame_valid", 32'(frame_valid), 1);
    chk("arst_frame_fill", 32'(fill_count), 0);
    chk_frame("arst_frame_par");

    n_checks++;
    assert (exp_q.size() == 0) n_pass++;
    else $error("FAIL sb_drain: got %0d left want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
